// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed, checksummed byte stream, writes 32-bit
// little-endian words into instruction RAM and releases the CPU on success.
module program_loader #(
  parameter int ADRS_W = 8
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADRS_W-1:0] ram_adrs,
  output logic [31:0]       ram_d,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADRS_W:0]   words_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;

  localparam logic [32:0] MAX_LEN = 33'(1) << ADRS_W;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADRS_W:0]   len_q, len_d;
  logic [31:0]       sum_q, sum_d;
  logic [ADRS_W:0]   wl_q, wl_d;
  logic              ram_we_q, ram_we_d;
  logic [ADRS_W-1:0] ram_adrs_q, ram_adrs_d;
  logic [31:0]       ram_d_q, ram_d_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept, word_last;
  logic [31:0]       full_word;
  logic [ADRS_W:0]   wl_nxt;

  assign accept    = rx_valid & rx_ready_q;
  assign word_last = accept && (idx_q == 2'd3);
  assign full_word = {rx_data, word_q[23:0]};
  assign wl_nxt    = wl_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    len_d      = len_q;
    sum_d      = sum_q;
    wl_d       = wl_q;
    ram_we_d   = 1'b0;
    ram_adrs_d = ram_adrs_q;
    ram_d_d    = ram_d_q;

    if (accept) begin
      idx_d = idx_q + 2'd1;
      word_d[{idx_q, 3'b000} +: 8] = rx_data;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          sum_d   = '0;
          wl_d    = '0;
          idx_d   = '0;
        end
      end
      S_LEN: begin
        if (word_last) begin
          len_d = full_word[ADRS_W:0];
          if (full_word == 32'd0)               state_d = S_SUM;
          else if ({1'b0, full_word} > MAX_LEN) state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Write lands the cycle after the last byte; the stream keeps flowing.
        if (word_last) begin
          ram_we_d   = 1'b1;
          ram_adrs_d = wl_q[ADRS_W-1:0];
          ram_d_d    = full_word;
          sum_d      = sum_q + full_word;
          wl_d       = wl_nxt;
          if (wl_nxt == len_q) state_d = S_SUM;
        end
      end
      S_SUM: begin
        if (word_last) state_d = (full_word == sum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_SUM);
    rx_ready_d  = busy_d;
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      wl_q        <= '0;
      ram_we_q    <= 1'b0;
      ram_adrs_q  <= '0;
      ram_d_q     <= '0;
      cpu_reset_q <= 1'b1;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wl_q        <= wl_d;
      ram_we_q    <= ram_we_d;
      ram_adrs_q  <= ram_adrs_d;
      ram_d_q     <= ram_d_d;
      cpu_reset_q <= cpu_reset_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign ram_we       = ram_we_q;
  assign ram_adrs     = ram_adrs_q;
  assign ram_d        = ram_d_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader built with a 4-word RAM so the length
// limits are reachable; RAM writes are logged and compared to hand values.
module tb_program_loader;
  localparam int AW = 2;

  logic          clk_cpu = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, ram_we, cpu_reset, busy, done, error;
  logic [AW-1:0] ram_adrs;
  logic [31:0]   ram_d;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int failures = 0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] exp_w[4];

  program_loader #(.ADRS_W(AW)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .ram_we(ram_we),
    .ram_adrs(ram_adrs), .ram_d(ram_d), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk_cpu = ~clk_cpu;

  always @(negedge clk_cpu)
    if (ram_we === 1'b1) begin
      wr_a.push_back(32'(ram_adrs));
      wr_d.push_back(ram_d);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk_cpu);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      @(negedge clk_cpu);
      rx_valid = 1'b0;
    end
    @(negedge clk_cpu);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 20 && rx_ready !== 1'b1; t++) @(negedge clk_cpu);
    if (rx_ready !== 1'b1) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    else @(posedge clk_cpu);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic idle_rx();
    @(negedge clk_cpu);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_cpu);
    start = 1'b1;
    @(negedge clk_cpu);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic check_wr(input string tag, input int n);
    chk($sformatf("%s_wcnt", tag), 32'(wr_d.size()), 32'(n));
    for (int i = 0; i < n && i < wr_d.size(); i++) begin
      chk($sformatf("%s_adrs%0d", tag, i), wr_a[i], 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_d[i], exp_w[i]);
    end
  endtask

  task automatic nominal(input bit gap, input logic [31:0] sum);
    send_word(32'd2, gap);
    send_word(32'h12345678, gap);
    send_word(32'h00000001, gap);
    send_word(sum, gap);
    idle_rx();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held 3 cycles with start asserted; start must be ignored.
    start = 1'b1;
    repeat (3) @(negedge clk_cpu);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    chk("rst_adrs", 32'(ram_adrs), 32'd0);
    chk("rst_d", ram_d, 32'd0);
    start = 1'b0;
    reset = 1'b1;

    // Bytes offered in IDLE are not taken.
    @(negedge clk_cpu);
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk_cpu);
    #1;
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    rx_valid = 1'b0;
    chk("idle_no_we", 32'(wr_d.size()), 32'd0);

    // Nominal load
    clear_log();
    pulse_start();
    #1;
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_rx_ready", 32'(rx_ready), 32'd1);
    nominal(1'b0, 32'h12345679);
    settle();
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'h00000001;
    check_wr("nom", 2);
    chk("nom_wl", 32'(words_loaded), 32'd2);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_rx_ready_off", 32'(rx_ready), 32'd0);

    // Bad checksum, restart from DONE reasserts cpu_reset
    clear_log();
    pulse_start();
    #1;
    chk("bad_cpu_reset_on_start", 32'(cpu_reset), 32'd1);
    chk("bad_wl_cleared", 32'(words_loaded), 32'd0);
    nominal(1'b0, 32'h00000000);
    settle();
    check_wr("bad", 2);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_start();
    #1;
    chk("bad_restart_rx_ready", 32'(rx_ready), 32'd1);
    chk("bad_restart_error", 32'(error), 32'd0);

    // N=5 exceeds a 4-word RAM
    clear_log();
    send_word(32'd5, 1'b0);
    idle_rx();
    settle();
    chk("n5_error", 32'(error), 32'd1);
    chk("n5_wl", 32'(words_loaded), 32'd0);
    chk("n5_no_we", 32'(wr_d.size()), 32'd0);

    // N=0 goes straight to the checksum
    pulse_start();
    send_word(32'd0, 1'b0);
    send_word(32'd0, 1'b0);
    idle_rx();
    settle();
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_no_we", 32'(wr_d.size()), 32'd0);
    chk("n0_cpu_reset", 32'(cpu_reset), 32'd0);

    // N=4 fills the RAM; checksum wraps past 2^32
    clear_log();
    pulse_start();
    exp_w[0] = 32'hA0000000;
    exp_w[1] = 32'h90000000;
    exp_w[2] = 32'h00000005;
    exp_w[3] = 32'h12345678;
    send_word(32'd4, 1'b0);
    for (int i = 0; i < 4; i++) send_word(exp_w[i], 1'b0);
    send_word(32'h4234567D, 1'b0);
    idle_rx();
    settle();
    check_wr("n4", 4);
    chk("n4_wl", 32'(words_loaded), 32'd4);
    chk("n4_done", 32'(done), 32'd1);

    // Gapped stream with a start pulse in the middle of DATA
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b1);
    send_word(32'h12345678, 1'b1);
    idle_rx();
    pulse_start();
    #1;
    chk("gap_busy_mid", 32'(busy), 32'd1);
    chk("gap_wl_mid", 32'(words_loaded), 32'd1);
    send_word(32'h00000001, 1'b1);
    send_word(32'h12345679, 1'b1);
    idle_rx();
    settle();
    exp_w[0] = 32'h12345678;
    exp_w[1] = 32'h00000001;
    check_wr("gap", 2);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_wl", 32'(words_loaded), 32'd2);

    // Reset after 6 bytes of the nominal stream
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    @(negedge clk_cpu);
    reset = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_wl", 32'(words_loaded), 32'd0);
    chk("mid_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk_cpu);
    reset = 1'b1;
    settle();
    chk("mid_no_we", 32'(wr_d.size()), 32'd0);
    pulse_start();
    nominal(1'b0, 32'h12345679);
    settle();
    check_wr("post", 2);
    chk("post_done", 32'(done), 32'd1);
    chk("post_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
